// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite descriptor types and widths for the sprite display blocks.
package sprite_pkg;
    localparam int FIELD_W         = 16;
    localparam int ADDR_WIDTH      = 16;
    localparam int CNT_WIDTH       = 10;
    localparam int MAX_SCALE_SHIFT = 3;
    localparam int SHIFT_W         = $clog2(MAX_SCALE_SHIFT + 1);
    localparam logic [23:0] BG_COLOR = 24'h202020;

    typedef struct packed {
        logic [FIELD_W-1:0] append;
        logic [FIELD_W-1:0] res_h;
        logic [FIELD_W-1:0] res_v;
        logic [FIELD_W-1:0] act_h;
        logic [FIELD_W-1:0] act_v;
    } pattern_info_t;

    typedef struct packed {
        logic                 visible;
        logic                 flip;
        logic [CNT_WIDTH-1:0] x;
        logic [CNT_WIDTH-1:0] y;
        logic [9:0]           reserved;
    } sprite_info_t;
endpackage

// File: rtl/sprite_addr_cal_if.sv
// sprite_addr_cal_if: beam position and sprite descriptors in, texel address and hit flag out.
interface sprite_addr_cal_if import sprite_pkg::*;;
    pattern_info_t         pattern_info;
    sprite_info_t          sprite_info;
    logic [CNT_WIDTH-1:0]  hcount;
    logic [CNT_WIDTH-1:0]  vcount;
    logic [ADDR_WIDTH-1:0] addr_output;
    logic                  valid;

    modport master (
        output pattern_info, sprite_info, hcount, vcount,
        input  addr_output, valid
    );

    modport slave (
        input  pattern_info, sprite_info, hcount, vcount,
        output addr_output, valid
    );
endinterface

// File: rtl/sprite_axis_map.sv
// sprite_axis_map: per-axis hit test, power-of-two scale detection and texel index.
module sprite_axis_map import sprite_pkg::*; #(
    parameter int CNT_W = CNT_WIDTH
) (
    input  logic [CNT_W-1:0]   i_pos,
    input  logic [CNT_W-1:0]   i_origin,
    input  logic [FIELD_W-1:0] i_act,
    input  logic [FIELD_W-1:0] i_res,
    input  logic               i_mirror,
    output logic               o_inside,
    output logic [FIELD_W-1:0] o_index,
    output logic               o_scale_ok
);
    localparam int SUM_W = FIELD_W + 1;
    localparam int EXT_W = FIELD_W + MAX_SCALE_SHIFT;

    logic [SUM_W-1:0]   w_end;
    logic [EXT_W-1:0]   w_act_x;
    logic [EXT_W-1:0]   w_res_x;
    logic [SHIFT_W-1:0] w_shift;
    logic               w_match;
    logic [CNT_W-1:0]   w_dx;
    logic [FIELD_W-1:0] w_col;

    // 17-bit end point so sprites hanging off the right/bottom edge never wrap
    assign w_end    = SUM_W'(i_origin) + SUM_W'(i_act);
    assign o_inside = (i_pos >= i_origin) && (SUM_W'(i_pos) < w_end);

    assign w_act_x = EXT_W'(i_act);
    assign w_res_x = EXT_W'(i_res);

    always_comb begin
        w_shift = '0;
        w_match = 1'b0;
        for (int k = MAX_SCALE_SHIFT; k >= 0; k--) begin
            if (w_act_x == (w_res_x << k)) begin
                w_shift = SHIFT_W'(k);
                w_match = 1'b1;
            end
        end
    end

    assign o_scale_ok = w_match && (i_res != '0);

    assign w_dx    = i_pos - i_origin;
    assign w_col   = FIELD_W'(w_dx >> w_shift);
    assign o_index = i_mirror ? i_res - FIELD_W'(1) - w_col : w_col;
endmodule

// File: rtl/sprite_addr_cal.sv
// sprite_addr_cal: registered per-pixel sprite hit flag and color-index memory address.
module sprite_addr_cal import sprite_pkg::*; #(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int CNT_W  = CNT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    sprite_addr_cal_if.slave bus
);
    pattern_info_t      w_pat;
    sprite_info_t       w_spr;
    logic               w_in_h, w_in_v, w_ok_h, w_ok_v;
    logic [FIELD_W-1:0] w_col, w_row;
    logic               w_valid;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_unused_reserved;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_valid;

    assign w_pat             = bus.pattern_info;
    assign w_spr             = bus.sprite_info;
    assign w_unused_reserved = ^w_spr.reserved;

    sprite_axis_map #(.CNT_W(CNT_W)) u_map_h (
        .i_pos      (bus.hcount),
        .i_origin   (w_spr.x),
        .i_act      (w_pat.act_h),
        .i_res      (w_pat.res_h),
        .i_mirror   (w_spr.flip),
        .o_inside   (w_in_h),
        .o_index    (w_col),
        .o_scale_ok (w_ok_h)
    );

    sprite_axis_map #(.CNT_W(CNT_W)) u_map_v (
        .i_pos      (bus.vcount),
        .i_origin   (w_spr.y),
        .i_act      (w_pat.act_v),
        .i_res      (w_pat.res_v),
        .i_mirror   (1'b0),
        .o_inside   (w_in_v),
        .o_index    (w_row),
        .o_scale_ok (w_ok_v)
    );

    assign w_valid = w_spr.visible && w_in_h && w_in_v && w_ok_h && w_ok_v;
    // address wraps silently modulo 2^ADDR_W
    assign w_addr  = ADDR_W'(w_pat.append + w_row * w_pat.res_h + w_col);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_valid;
            r_addr  <= w_valid ? w_addr : '0;
        end
    end

    assign bus.addr_output = r_addr;
    assign bus.valid       = r_valid;
endmodule

// File: tb/tb_sprite_addr_cal.sv
// tb_sprite_addr_cal: directed vector table plus async-reset and latency sequences.
module tb_sprite_addr_cal;
    import sprite_pkg::*;

    typedef struct {
        pattern_info_t p;
        sprite_info_t  s;
        logic [9:0]    h;
        logic [9:0]    v;
        logic          ev;
        logic [15:0]   ea;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    sprite_addr_cal_if bus ();

    sprite_addr_cal dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic pattern_info_t pat(logic [15:0] a, logic [15:0] rh, logic [15:0] rv,
                                          logic [15:0] ah, logic [15:0] av);
        return '{append: a, res_h: rh, res_v: rv, act_h: ah, act_v: av};
    endfunction

    function automatic sprite_info_t spr(logic vis, logic fl, logic [9:0] x, logic [9:0] y);
        return '{visible: vis, flip: fl, x: x, y: y, reserved: 10'h3A5};
    endfunction

    function automatic vec_t mk(pattern_info_t p, sprite_info_t s, logic [9:0] h, logic [9:0] v,
                                logic ev, logic [15:0] ea);
        vec_t r;
        r.p = p; r.s = s; r.h = h; r.v = v; r.ev = ev; r.ea = ea;
        return r;
    endfunction

    task automatic chk(string name, logic ev, logic [15:0] ea);
        checks++;
        if (bus.valid !== ev || bus.addr_output !== ea) begin
            failures++;
            $display("FAIL %s: got valid=%0b addr=%h, want valid=%0b addr=%h",
                     name, bus.valid, bus.addr_output, ev, ea);
        end
    endtask

    task automatic drive(vec_t t);
        bus.pattern_info = t.p;
        bus.sprite_info  = t.s;
        bus.hcount       = t.h;
        bus.vcount       = t.v;
    endtask

    initial begin
        pattern_info_t p64;
        sprite_info_t  s0;
        p64 = pat(16'h0, 16'd64, 16'd64, 16'd64, 16'd64);
        s0  = spr(1'b1, 1'b0, 10'd100, 10'd50);
        vecs.push_back(mk(p64, s0, 10'd100, 10'd50, 1'b1, 16'd0));
        vecs.push_back(mk(p64, s0, 10'd163, 10'd113, 1'b1, 16'd4095));
        vecs.push_back(mk(p64, s0, 10'd164, 10'd60, 1'b0, 16'd0));
        vecs.push_back(mk(p64, s0, 10'd120, 10'd49, 1'b0, 16'd0));
        vecs.push_back(mk(p64, s0, 10'd99, 10'd50, 1'b0, 16'd0));
        vecs.push_back(mk(p64, s0, 10'd163, 10'd114, 1'b0, 16'd0));
        vecs.push_back(mk(p64, spr(1'b0, 1'b0, 10'd100, 10'd50), 10'd120, 10'd60, 1'b0, 16'd0));
        vecs.push_back(mk(p64, spr(1'b1, 1'b1, 10'd100, 10'd50), 10'd100, 10'd50, 1'b1, 16'd63));
        vecs.push_back(mk(p64, spr(1'b1, 1'b1, 10'd100, 10'd50), 10'd163, 10'd51, 1'b1, 16'd64));
        vecs.push_back(mk(pat(16'h0100, 16'd32, 16'd32, 16'd64, 16'd64), spr(1'b1, 1'b0, 10'd0, 10'd0),
                          10'd3, 10'd5, 1'b1, 16'h0141));
        vecs.push_back(mk(pat(16'h0100, 16'd32, 16'd32, 16'd64, 16'd64), spr(1'b1, 1'b1, 10'd0, 10'd0),
                          10'd3, 10'd5, 1'b1, 16'h015E));
        vecs.push_back(mk(pat(16'h0, 16'd32, 16'd32, 16'd48, 16'd64), spr(1'b1, 1'b0, 10'd0, 10'd0),
                          10'd3, 10'd5, 1'b0, 16'd0));
        vecs.push_back(mk(pat(16'h0, 16'd32, 16'd32, 16'd48, 16'd64), spr(1'b1, 1'b0, 10'd0, 10'd0),
                          10'd0, 10'd0, 1'b0, 16'd0));
        vecs.push_back(mk(p64, spr(1'b1, 1'b0, 10'd1000, 10'd50), 10'd1023, 10'd50, 1'b1, 16'd23));
        vecs.push_back(mk(p64, spr(1'b1, 1'b0, 10'd1000, 10'd50), 10'd5, 10'd50, 1'b0, 16'd0));
        vecs.push_back(mk(p64, spr(1'b1, 1'b0, 10'd100, 10'd1000), 10'd100, 10'd1023, 1'b1, 16'd1472));
        vecs.push_back(mk(pat(16'hFFFF, 16'd64, 16'd64, 16'd64, 16'd64), s0, 10'd101, 10'd50, 1'b1, 16'h0000));
        vecs.push_back(mk(pat(16'h0, 16'd8, 16'd8, 16'd64, 16'd64), s0, 10'd163, 10'd113, 1'b1, 16'd63));
        vecs.push_back(mk(pat(16'h0, 16'd16, 16'd64, 16'd64, 16'd64), s0, 10'd110, 10'd53, 1'b1, 16'd50));
        vecs.push_back(mk(pat(16'h0, 16'd0, 16'd64, 16'd64, 16'd64), s0, 10'd100, 10'd50, 1'b0, 16'd0));
        vecs.push_back(mk(pat(16'h0, 16'd64, 16'd64, 16'd0, 16'd64), s0, 10'd100, 10'd50, 1'b0, 16'd0));
        vecs.push_back(mk(pat(16'h0, 16'd64, 16'd64, 16'd64, 16'd0), s0, 10'd100, 10'd50, 1'b0, 16'd0));

        drive(vecs[0]);
        #1;
        chk("reset_state", 1'b0, 16'd0);
        @(posedge clk);
        #1;
        chk("reset_held_over_edge", 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea);
        end

        drive(vecs[1]);
        @(posedge clk);
        #1;
        drive(vecs[2]);
        #2;
        chk("latency_hold_before_edge", 1'b1, 16'd4095);
        @(posedge clk);
        #1;
        chk("latency_miss_after_edge", 1'b0, 16'd0);

        drive(vecs[1]);
        @(posedge clk);
        #1;
        chk("pre_reset_hit", 1'b1, 16'd4095);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_no_clk", 1'b0, 16'd0);
        @(posedge clk);
        #1;
        chk("reset_held_hit_input", 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("after_release_no_edge", 1'b0, 16'd0);
        @(posedge clk);
        #1;
        chk("hit_after_release", 1'b1, 16'd4095);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
